// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage and its prefetch queue.
// Default geometry matches the loader/debug unit and the ID stage.
package if_prefetch_unit_pkg;

  localparam int BYTE_SIZE                               = 8;
  localparam int DEFAULT_PC_SIZE                         = 32;
  localparam int DEFAULT_INSTRUCTION_MEMORY_WORD_BYTES   = 4;
  localparam int DEFAULT_INSTRUCTION_MEMORY_SIZE_IN_WORDS = 64;
  localparam int DEFAULT_FETCH_QUEUE_DEPTH               = 4;

  // Queue operation for one edge, derived from the push/pop strobes.
  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    return q_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bus bundle between the fetch stage, the loader (memory writes/control) and decode.
// The slave modport is the fetch stage's view; master is the driver side.
interface if_prefetch_unit_if
  import if_prefetch_unit_pkg::*;
#(
  parameter int PC_SIZE            = DEFAULT_PC_SIZE,
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_INSTRUCTION_MEMORY_WORD_BYTES,
  parameter int QUEUE_DEPTH        = DEFAULT_FETCH_QUEUE_DEPTH
) ();

  localparam int BUS = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);

  logic               i_enable;
  logic               i_halt;
  logic               i_load_mode;
  logic               i_write_mem;
  logic               i_clear_mem;
  logic [BUS-1:0]     i_instruction;
  logic               i_redirect;
  logic [PC_SIZE-1:0] i_redirect_pc;
  logic               i_ready;
  logic               o_valid;
  logic [BUS-1:0]     o_instruction;
  logic [PC_SIZE-1:0] o_pc;
  logic [PC_SIZE-1:0] o_next_seq_pc;
  logic [CW-1:0]      o_queue_count;
  logic               o_full_mem;
  logic               o_empty_mem;
  logic               o_end_of_program;

  modport slave (
    input  i_enable, i_halt, i_load_mode, i_write_mem, i_clear_mem, i_instruction,
           i_redirect, i_redirect_pc, i_ready,
    output o_valid, o_instruction, o_pc, o_next_seq_pc, o_queue_count,
           o_full_mem, o_empty_mem, o_end_of_program
  );

  modport master (
    output i_enable, i_halt, i_load_mode, i_write_mem, i_clear_mem, i_instruction,
           i_redirect, i_redirect_pc, i_ready,
    input  o_valid, o_instruction, o_pc, o_next_seq_pc, o_queue_count,
           o_full_mem, o_empty_mem, o_end_of_program
  );

endinterface

// File: rtl/if_prefetch_unit_fetch_queue.sv
// Synchronous FIFO of {pc, instruction} with flush; head reads zero when empty.
// Push while full is only legal together with a pop (caller guarantees this).
module if_prefetch_unit_fetch_queue
  import if_prefetch_unit_pkg::*;
#(
  parameter int PC_SIZE     = DEFAULT_PC_SIZE,
  parameter int BUS         = DEFAULT_INSTRUCTION_MEMORY_WORD_BYTES * BYTE_SIZE,
  parameter int QUEUE_DEPTH = DEFAULT_FETCH_QUEUE_DEPTH
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 flush,
  input  logic                                 push,
  input  logic                                 pop,
  input  logic [PC_SIZE-1:0]                   push_pc,
  input  logic [BUS-1:0]                       push_instruction,
  output logic                                 head_valid,
  output logic [PC_SIZE-1:0]                   head_pc,
  output logic [BUS-1:0]                       head_instruction,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [PC_SIZE-1:0] store_pc    [QUEUE_DEPTH];
  logic [BUS-1:0]     store_instr [QUEUE_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count_q;
  q_op_e              op;

  always_comb begin
    op = q_op(push, pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      unique case (op)
        Q_PUSH: begin
          wr_ptr  <= wr_ptr + 1'b1;
          count_q <= count_q + 1'b1;
        end
        Q_POP: begin
          rd_ptr  <= rd_ptr + 1'b1;
          count_q <= count_q - 1'b1;
        end
        Q_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !flush && push) begin
      store_pc[wr_ptr]    <= push_pc;
      store_instr[wr_ptr] <= push_instruction;
    end
  end

  always_comb begin
    head_valid       = (count_q != '0);
    head_pc          = head_valid ? store_pc[rd_ptr]    : '0;
    head_instruction = head_valid ? store_instr[rd_ptr] : '0;
    count            = count_q;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: loadable instruction memory, PC, and a prefetch queue feeding decode.
// Fetch stops once the PC word index reaches the loaded-program end (write pointer).
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int PC_SIZE            = DEFAULT_PC_SIZE,
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_INSTRUCTION_MEMORY_WORD_BYTES,
  parameter int MEM_SIZE_IN_WORDS  = DEFAULT_INSTRUCTION_MEMORY_SIZE_IN_WORDS,
  parameter int QUEUE_DEPTH        = DEFAULT_FETCH_QUEUE_DEPTH
) (
  input  logic                i_clk,
  input  logic                i_reset,
  if_prefetch_unit_if.slave   bus
);

  localparam int BUS = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int OFS = $clog2(WORD_SIZE_IN_BYTES);
  localparam int AW  = $clog2(MEM_SIZE_IN_WORDS);
  localparam int WPW = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam int IW  = PC_SIZE - OFS;
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);

  logic [PC_SIZE-1:0] pc_q;
  logic [WPW-1:0]     wptr_q;
  logic [BUS-1:0]     mem [MEM_SIZE_IN_WORDS];

  logic [IW-1:0]      fetch_idx;
  logic [BUS-1:0]     fetch_word;
  logic               full_mem;
  logic               end_of_program;
  logic               take_redirect;
  logic               pop;
  logic               push;
  logic               q_flush;
  logic               head_valid;
  logic [PC_SIZE-1:0] head_pc;
  logic [BUS-1:0]     head_instruction;
  logic [CW-1:0]      q_count;

  always_comb begin
    fetch_idx      = pc_q[PC_SIZE-1:OFS];
    fetch_word     = mem[fetch_idx[AW-1:0]];
    full_mem       = (wptr_q == WPW'(MEM_SIZE_IN_WORDS));
    // Full-width index compare keeps fetch from wrapping into unloaded words.
    end_of_program = (fetch_idx >= IW'(wptr_q));
    take_redirect  = bus.i_enable && bus.i_redirect;
    pop            = bus.i_enable && head_valid && bus.i_ready;
    push           = bus.i_enable && !bus.i_halt && !bus.i_load_mode && !end_of_program &&
                     !bus.i_redirect && ((q_count < CW'(QUEUE_DEPTH)) || pop);
    q_flush        = bus.i_clear_mem || take_redirect;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q <= '0;
    end else if (bus.i_clear_mem) begin
      pc_q <= '0;
    end else if (take_redirect) begin
      pc_q <= bus.i_redirect_pc & ~PC_SIZE'(WORD_SIZE_IN_BYTES - 1);
    end else if (push) begin
      pc_q <= pc_q + PC_SIZE'(WORD_SIZE_IN_BYTES);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_clear_mem) begin
      wptr_q <= '0;
    end else if (bus.i_write_mem && !full_mem) begin
      wptr_q <= wptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && !bus.i_clear_mem && bus.i_write_mem && !full_mem) begin
      mem[wptr_q[AW-1:0]] <= bus.i_instruction;
    end
  end

  if_prefetch_unit_fetch_queue #(
    .PC_SIZE     (PC_SIZE),
    .BUS         (BUS),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .flush            (q_flush),
    .push             (push),
    .pop              (pop),
    .push_pc          (pc_q),
    .push_instruction (fetch_word),
    .head_valid       (head_valid),
    .head_pc          (head_pc),
    .head_instruction (head_instruction),
    .count            (q_count)
  );

  always_comb begin
    bus.o_valid          = head_valid;
    bus.o_instruction    = head_instruction;
    bus.o_pc             = head_pc;
    bus.o_next_seq_pc    = head_valid ? head_pc + PC_SIZE'(WORD_SIZE_IN_BYTES) : '0;
    bus.o_queue_count    = q_count;
    bus.o_full_mem       = full_mem;
    bus.o_empty_mem      = (wptr_q == '0);
    bus.o_end_of_program = end_of_program;
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed scenarios plus random traffic, all checked each cycle
// against a queue-based behavioural model; a few literal expectations pin the model.
module tb_if_prefetch_unit;

  logic i_clk;
  logic i_reset;

  if_prefetch_unit_if #(.PC_SIZE(32), .WORD_SIZE_IN_BYTES(4), .QUEUE_DEPTH(4)) bus ();

  if_prefetch_unit #(
    .PC_SIZE(32), .WORD_SIZE_IN_BYTES(4), .MEM_SIZE_IN_WORDS(64), .QUEUE_DEPTH(4)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic [31:0] m_mem [64];
  int unsigned m_wptr;
  logic [31:0] m_pc;
  ent_t        m_q [$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Next-state of the model from the rules: reset > clear > redirect > push/pop.
  task automatic model_step();
    ent_t e;
    bit   full, eop, pop, push, redir;
    e = '{32'd0, 32'd0};
    if (i_reset) begin
      m_pc = 0; m_wptr = 0; m_q.delete();
      return;
    end
    if (bus.i_clear_mem) begin
      m_pc = 0; m_wptr = 0; m_q.delete();
      return;
    end
    full  = (m_wptr == 64);
    eop   = ((m_pc >> 2) >= m_wptr);
    pop   = bus.i_enable && (m_q.size() != 0) && bus.i_ready;
    redir = bus.i_enable && bus.i_redirect;
    push  = bus.i_enable && !bus.i_halt && !bus.i_load_mode && !eop && !bus.i_redirect &&
            ((m_q.size() < 4) || pop);
    if (push) e = '{m_pc, m_mem[int'(m_pc >> 2)]};
    if (bus.i_write_mem && !full) begin
      m_mem[m_wptr] = bus.i_instruction;
      m_wptr++;
    end
    if (redir) begin
      m_q.delete();
      m_pc = bus.i_redirect_pc & ~32'd3;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (m_q.size() != 0);
    chk("valid",      64'(bus.o_valid),          64'(v));
    chk("instr",      64'(bus.o_instruction),    v ? 64'(m_q[0].instr) : 64'd0);
    chk("pc",         64'(bus.o_pc),             v ? 64'(m_q[0].pc) : 64'd0);
    chk("next_seq",   64'(bus.o_next_seq_pc),    v ? 64'(m_q[0].pc + 32'd4) : 64'd0);
    chk("count",      64'(bus.o_queue_count),    64'(m_q.size()));
    chk("full_mem",   64'(bus.o_full_mem),       64'(m_wptr == 64));
    chk("empty_mem",  64'(bus.o_empty_mem),      64'(m_wptr == 0));
    chk("end_of_prog",64'(bus.o_end_of_program), 64'((m_pc >> 2) >= m_wptr));
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.i_enable = 0; bus.i_halt = 0; bus.i_load_mode = 0; bus.i_write_mem = 0;
    bus.i_clear_mem = 0; bus.i_instruction = '0; bus.i_redirect = 0;
    bus.i_redirect_pc = '0; bus.i_ready = 0;
  endtask

  task automatic load_word(input logic [31:0] w);
    bus.i_load_mode = 1; bus.i_write_mem = 1; bus.i_instruction = w;
    tick();
    bus.i_write_mem = 0;
  endtask

  task automatic clear_and_load(input int n);
    idle_inputs();
    bus.i_clear_mem = 1; tick(); bus.i_clear_mem = 0;
    for (int i = 0; i < n; i++) load_word(32'h100 + 32'(i));
    bus.i_load_mode = 0;
  endtask

  logic [31:0] word63;

  initial begin
    idle_inputs();
    i_reset = 1;
    tick();
    i_reset = 0;
    chk("lit_reset_valid", 64'(bus.o_valid), 64'd0);
    chk("lit_reset_pc",    64'(bus.o_pc), 64'd0);
    chk("lit_reset_next",  64'(bus.o_next_seq_pc), 64'd0);
    chk("lit_reset_empty", 64'(bus.o_empty_mem), 64'd1);
    chk("lit_reset_eop",   64'(bus.o_end_of_program), 64'd1);

    // Three-word program streamed with ready held high
    load_word(32'h11);
    chk("lit_s1_empty", 64'(bus.o_empty_mem), 64'd0);
    load_word(32'h22);
    load_word(32'h33);
    bus.i_load_mode = 0; bus.i_enable = 1; bus.i_ready = 1;
    tick();
    chk("lit_s1_pc0", 64'(bus.o_pc), 64'h0);  chk("lit_s1_w0", 64'(bus.o_instruction), 64'h11);
    tick();
    chk("lit_s1_pc1", 64'(bus.o_pc), 64'h4);  chk("lit_s1_w1", 64'(bus.o_instruction), 64'h22);
    tick();
    chk("lit_s1_pc2", 64'(bus.o_pc), 64'h8);  chk("lit_s1_w2", 64'(bus.o_instruction), 64'h33);
    chk("lit_s1_eop", 64'(bus.o_end_of_program), 64'd1);
    tick();
    chk("lit_s1_drained", 64'(bus.o_valid), 64'd0);

    // Backpressure saturates the queue, then drain in order
    clear_and_load(8);
    bus.i_enable = 1; bus.i_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("lit_s2_count", 64'(bus.o_queue_count), 64'd4);
    chk("lit_s2_head",  64'(bus.o_instruction), 64'h100);
    bus.i_ready = 1;
    tick();
    chk("lit_s2_w1", 64'(bus.o_instruction), 64'h101);
    tick();

    // Redirect mid-stream to a misaligned target
    bus.i_redirect = 1; bus.i_redirect_pc = 32'h16;
    tick();
    bus.i_redirect = 0;
    chk("lit_s3_flush", 64'(bus.o_queue_count), 64'd0);
    tick();
    chk("lit_s3_pc",   64'(bus.o_pc), 64'h14);
    chk("lit_s3_word", 64'(bus.o_instruction), 64'h105);
    chk("lit_s3_next", 64'(bus.o_next_seq_pc), 64'h18);
    for (int i = 0; i < 4; i++) tick();

    // Fill memory, ignored overflow write, then clear
    idle_inputs();
    bus.i_clear_mem = 1; tick(); bus.i_clear_mem = 0;
    word63 = '0;
    for (int i = 0; i < 64; i++) begin
      word63 = $urandom;
      load_word(word63);
    end
    chk("lit_s4_full", 64'(bus.o_full_mem), 64'd1);
    load_word(32'hDEAD_BEEF);
    chk("lit_s4_still_full", 64'(bus.o_full_mem), 64'd1);
    bus.i_load_mode = 0; bus.i_enable = 1; bus.i_ready = 0;
    bus.i_redirect = 1; bus.i_redirect_pc = 32'hFC;
    tick();
    bus.i_redirect = 0;
    tick();
    chk("lit_s4_word63", 64'(bus.o_instruction), 64'(word63));
    bus.i_clear_mem = 1; bus.i_write_mem = 1; bus.i_instruction = 32'h5A5A;
    tick();
    bus.i_clear_mem = 0; bus.i_write_mem = 0;
    chk("lit_s4_empty", 64'(bus.o_empty_mem), 64'd1);
    chk("lit_s4_count", 64'(bus.o_queue_count), 64'd0);
    chk("lit_s4_pc",    64'(bus.o_pc), 64'd0);

    // Halt drains the queue without new fetches; then step-mode freeze
    clear_and_load(8);
    bus.i_enable = 1; bus.i_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("lit_s5_count3", 64'(bus.o_queue_count), 64'd3);
    bus.i_halt = 1; bus.i_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("lit_s5_drained", 64'(bus.o_queue_count), 64'd0);
    bus.i_halt = 0;
    tick();
    chk("lit_s5_resume", 64'(bus.o_pc), 64'hC);
    bus.i_enable = 0;
    for (int i = 0; i < 5; i++) begin
      bus.i_redirect = 1'($urandom); bus.i_halt = 1'($urandom);
      bus.i_redirect_pc = 32'($urandom_range(0, 64));
      tick();
    end
    chk("lit_s5_frozen_pc", 64'(bus.o_pc), 64'hC);
    idle_inputs();

    // Reset with three entries queued
    clear_and_load(8);
    bus.i_enable = 1; bus.i_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    i_reset = 1; tick(); i_reset = 0;
    chk("lit_s6_valid", 64'(bus.o_valid), 64'd0);
    chk("lit_s6_count", 64'(bus.o_queue_count), 64'd0);
    chk("lit_s6_empty", 64'(bus.o_empty_mem), 64'd1);
    chk("lit_s6_pc",    64'(bus.o_pc), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.i_enable      = ($urandom_range(0, 9) != 0);
      bus.i_halt        = ($urandom_range(0, 9) == 0);
      bus.i_load_mode   = ($urandom_range(0, 19) == 0);
      bus.i_write_mem   = ($urandom_range(0, 4) == 0);
      bus.i_clear_mem   = ($urandom_range(0, 199) == 0);
      bus.i_instruction = $urandom;
      bus.i_redirect    = ($urandom_range(0, 19) == 0);
      bus.i_redirect_pc = 32'($urandom_range(0, 'h120));
      bus.i_ready       = ($urandom_range(0, 9) < 6);
      i_reset           = ($urandom_range(0, 499) == 0);
      tick();
    end
    i_reset = 0;
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
